// File: rtl/display_refresh_scheduler_pkg.sv
// Shared types and constants for the display refresh scheduler and its helpers.
package display_refresh_scheduler_pkg;

  localparam int DEF_SEG_WIDTH  = 8;
  localparam int DEF_NUM_DIGITS = 4;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_START   = 3'd2,
    S_WAIT_HI = 3'd3,
    S_WAIT_LO = 3'd4,
    S_LATCH   = 3'd5
  } state_e;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/display_refresh_scheduler_strobe_divider.sv
// Free-running divider producing a one-cycle strobe every CLK_DIV enabled cycles.
module display_refresh_scheduler_strobe_divider
  import display_refresh_scheduler_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_stb
);

  localparam int CNT_W = cnt_width(CLK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_clear) begin
      cnt_d = '0;
    end else if (i_enable) begin
      cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_stb = i_enable && (cnt_q == CNT_LAST);

endmodule

// File: rtl/display_refresh_scheduler.sv
// Scans a multi-digit segment display through a shared serial shift/latch chain,
// one digit per refresh tick, and paces the shifter with a divided clock strobe.
module display_refresh_scheduler
  import display_refresh_scheduler_pkg::*;
#(
  parameter int SEG_WIDTH    = DEF_SEG_WIDTH,
  parameter int NUM_DIGITS   = DEF_NUM_DIGITS,
  parameter int WIDTH        = SEG_WIDTH + NUM_DIGITS,
  parameter int CLK_DIV      = 4,
  parameter int LATCH_CYCLES = 2,
  localparam int IDX_W       = cnt_width(NUM_DIGITS)
) (
  input  logic                            i_clk,
  input  logic                            i_reset_n,
  input  logic                            i_enable,
  input  logic                            i_refresh_stb,
  input  logic [SEG_WIDTH*NUM_DIGITS-1:0] i_digits,
  output logic [WIDTH-1:0]                o_sr_data,
  output logic                            o_sr_start_stb,
  output logic                            o_sr_clk_stb,
  input  logic                            i_sr_busy,
  output logic                            o_serial_latch,
  output logic [IDX_W-1:0]                o_digit_idx,
  output logic                            o_frame_done
);

  localparam int LAT_W = cnt_width(LATCH_CYCLES);
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(LATCH_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  state_e             state_q,   state_d;
  logic [IDX_W-1:0]   idx_q,     idx_d;
  logic               pending_q, pending_d;
  logic               wait_q,    wait_d;
  logic [LAT_W-1:0]   lat_cnt_q, lat_cnt_d;
  logic [WIDTH-1:0]   sr_data_q, sr_data_d;

  logic [SEG_WIDTH-1:0]  digit_arr [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] digit_sel;
  logic                  div_clear;
  logic                  div_enable;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      assign digit_arr[gi] = i_digits[gi*SEG_WIDTH +: SEG_WIDTH];
    end
  endgenerate

  always_comb begin
    digit_sel = '0;
    digit_sel[idx_q] = 1'b1;
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    pending_d = pending_q;
    wait_d    = wait_q;
    lat_cnt_d = lat_cnt_q;
    sr_data_d = sr_data_q;

    // Ticks arriving mid-transfer are remembered once; extras fall away.
    if (i_refresh_stb && (state_q != S_IDLE)) begin
      pending_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        pending_d = 1'b0;
        if (i_enable && (i_refresh_stb || pending_q)) begin
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        sr_data_d = {digit_sel, digit_arr[idx_q]};
        state_d   = S_START;
      end
      S_START: begin
        wait_d    = 1'b0;
        lat_cnt_d = '0;
        state_d   = S_WAIT_HI;
      end
      S_WAIT_HI: begin
        // A shifter that never raises busy is taken as a zero-length transfer.
        if (i_sr_busy) begin
          state_d = S_WAIT_LO;
        end else if (wait_q) begin
          state_d = S_LATCH;
        end else begin
          wait_d = 1'b1;
        end
      end
      S_WAIT_LO: begin
        if (!i_sr_busy) begin
          state_d = S_LATCH;
        end
      end
      S_LATCH: begin
        if (lat_cnt_q == LAT_LAST) begin
          idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
          state_d = S_IDLE;
        end else begin
          lat_cnt_d = lat_cnt_q + LAT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (!i_enable) begin
      pending_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      pending_q <= 1'b0;
      wait_q    <= 1'b0;
      lat_cnt_q <= '0;
      sr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      pending_q <= pending_d;
      wait_q    <= wait_d;
      lat_cnt_q <= lat_cnt_d;
      sr_data_q <= sr_data_d;
    end
  end

  assign div_clear  = (state_q == S_START);
  assign div_enable = (state_q == S_WAIT_HI) || (state_q == S_WAIT_LO);

  display_refresh_scheduler_strobe_divider #(
    .CLK_DIV (CLK_DIV)
  ) u_strobe_divider (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_clear   (div_clear),
    .i_enable  (div_enable),
    .o_stb     (o_sr_clk_stb)
  );

  assign o_sr_data      = sr_data_q;
  assign o_sr_start_stb = (state_q == S_START);
  assign o_serial_latch = (state_q == S_LATCH);
  assign o_digit_idx    = idx_q;
  assign o_frame_done   = (state_q == S_LATCH) && (lat_cnt_q == LAT_LAST) && (idx_q == IDX_LAST);

endmodule

// File: tb/tb_display_refresh_scheduler.sv
// Scenario bench for display_refresh_scheduler with a behavioural shifter and scan model.
module tb_display_refresh_scheduler;

  localparam int SEG = 8;
  localparam int ND  = 4;
  localparam int W   = SEG + ND;
  localparam int DIV = 4;
  localparam int LC  = 2;
  localparam int IW  = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic          tick;
  logic [31:0]   digits;
  logic          busy;
  logic [W-1:0]  o_sr_data;
  logic          o_sr_start_stb;
  logic          o_sr_clk_stb;
  logic          o_serial_latch;
  logic [IW-1:0] o_digit_idx;
  logic          o_frame_done;

  display_refresh_scheduler #(
    .SEG_WIDTH(SEG), .NUM_DIGITS(ND), .WIDTH(W), .CLK_DIV(DIV), .LATCH_CYCLES(LC)
  ) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_enable(en), .i_refresh_stb(tick),
    .i_digits(digits), .o_sr_data(o_sr_data), .o_sr_start_stb(o_sr_start_stb),
    .o_sr_clk_stb(o_sr_clk_stb), .i_sr_busy(busy), .o_serial_latch(o_serial_latch),
    .o_digit_idx(o_digit_idx), .o_frame_done(o_frame_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int pass_cnt = 0;
  int total_cnt = 0;
  int mdl_idx = 0;

  int           start_cyc_q[$];
  logic [W-1:0] start_word_q[$];
  logic [W-1:0] shift_word_q[$];
  int           lat_len_q[$];
  int           lat_rise_q[$];
  int           lat_gap_q[$];
  int           fd_len_q[$];
  int           drop_cyc = 0;
  bit           sr_dead = 1'b0;

  // Expected parallel word: one-hot digit select above that digit's segments.
  function automatic logic [W-1:0] exp_word(input logic [31:0] d, input int idx);
    logic [W-1:0] w;
    logic [31:0]  t;
    t = d >> (idx * SEG);
    w = '0;
    w[SEG + idx] = 1'b1;
    w[SEG-1:0] = t[SEG-1:0];
    return w;
  endfunction

  // Shifter model: busy from the start strobe until WIDTH pacing strobes are seen.
  initial begin : shifter
    int  cnt;
    bit  active;
    busy = 1'b0; cnt = 0; active = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        busy = 1'b0; active = 1'b0;
      end else if (active) begin
        if (o_sr_clk_stb) begin
          cnt++;
          if (cnt == W) begin
            busy = 1'b0; active = 1'b0; drop_cyc = cyc;
            shift_word_q.push_back(o_sr_data);
          end
        end
      end else if (o_sr_start_stb && !sr_dead) begin
        busy = 1'b1; active = 1'b1; cnt = 0;
      end
    end
  end

  initial begin : monitor
    int cur_len;
    bit prev_lat;
    cur_len = 0; prev_lat = 1'b0;
    forever begin
      @(negedge clk);
      if (o_sr_start_stb) begin
        start_cyc_q.push_back(cyc);
        start_word_q.push_back(o_sr_data);
      end
      if (o_serial_latch) begin
        if (!prev_lat) begin
          cur_len = 0;
          lat_rise_q.push_back(cyc);
          lat_gap_q.push_back(cyc - drop_cyc);
        end
        cur_len++;
      end else if (prev_lat) begin
        lat_len_q.push_back(cur_len);
      end
      if (o_frame_done) fd_len_q.push_back(o_serial_latch ? cur_len : -1);
      prev_lat = o_serial_latch;
    end
  end

  task automatic pulse_tick();
    @(posedge clk); #1 tick = 1'b1;
    @(posedge clk); #1 tick = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    mdl_idx = 0;
  endtask

  task automatic wait_latches(input int target, input int budget, input string name);
    for (int i = 0; i < budget && lat_len_q.size() < target; i++) @(posedge clk);
    #1;
    total_cnt++;
    if (lat_len_q.size() < target) $display("FAIL %s_timeout: latches %0d want %0d", name, lat_len_q.size(), target);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; tick = 1'b0; digits = 32'hFFFF_FFFF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total_cnt++; if (o_sr_data !== '0) $display("FAIL reset_data: got %h want 0", o_sr_data); else pass_cnt++;
    total_cnt++; if (o_sr_start_stb !== 1'b0) $display("FAIL reset_start: got %b want 0", o_sr_start_stb); else pass_cnt++;
    total_cnt++; if (o_sr_clk_stb !== 1'b0) $display("FAIL reset_clkstb: got %b want 0", o_sr_clk_stb); else pass_cnt++;
    total_cnt++; if (o_serial_latch !== 1'b0) $display("FAIL reset_latch: got %b want 0", o_serial_latch); else pass_cnt++;
    total_cnt++; if (o_digit_idx !== '0) $display("FAIL reset_idx: got %0d want 0", o_digit_idx); else pass_cnt++;
    total_cnt++; if (o_frame_done !== 1'b0) $display("FAIL reset_fd: got %b want 0", o_frame_done); else pass_cnt++;
    @(posedge clk); #1 rst_n = 1'b1; mdl_idx = 0;
    $display("test_reset done");
  endtask

  task automatic test_single();
    int s0, l0;
    logic [3:0] pat;
    digits = {$urandom_range(0, 32'hFFFFFF) , 8'hA5};
    digits[31:8] = 24'($urandom);
    en = 1'b1;
    s0 = start_word_q.size(); l0 = lat_len_q.size();
    pulse_tick();
    @(negedge clk);
    total_cnt++; if (o_sr_start_stb !== 1'b0) $display("FAIL single_load_cycle: start %b want 0", o_sr_start_stb); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (o_sr_start_stb !== 1'b1) $display("FAIL single_start: start %b want 1", o_sr_start_stb); else pass_cnt++;
    total_cnt++; if (o_sr_data !== 12'h1A5) $display("FAIL single_word: got %h want 1a5", o_sr_data); else pass_cnt++;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); pat[k] = o_sr_clk_stb;
    end
    total_cnt++; if (pat !== 4'b1000) $display("FAIL single_clkstb_phase: got %b want 1000", pat); else pass_cnt++;
    wait_latches(l0 + 1, 300, "single");
    total_cnt++; if (lat_len_q[l0] != LC) $display("FAIL single_latch_len: got %0d want %0d", lat_len_q[l0], LC); else pass_cnt++;
    total_cnt++; if (lat_gap_q[l0] != 1) $display("FAIL single_latch_gap: got %0d want 1", lat_gap_q[l0]); else pass_cnt++;
    total_cnt++; if (start_word_q.size() != s0 + 1) $display("FAIL single_start_count: got %0d want %0d", start_word_q.size() - s0, 1); else pass_cnt++;
    mdl_idx = (mdl_idx + 1) % ND;
    total_cnt++; if (o_digit_idx !== IW'(mdl_idx)) $display("FAIL single_idx: got %0d want %0d", o_digit_idx, mdl_idx); else pass_cnt++;
    $display("test_single done");
  endtask

  task automatic test_frame();
    int s0, l0, f0;
    do_reset();
    digits = 32'h4433_2211;
    s0 = start_word_q.size(); l0 = lat_len_q.size(); f0 = fd_len_q.size();
    for (int i = 0; i < ND; i++) begin
      pulse_tick();
      wait_latches(l0 + i + 1, 300, "frame");
      idle(5);
    end
    for (int i = 0; i < ND; i++) begin
      total_cnt++;
      if (start_word_q[s0 + i] !== exp_word(digits, i))
        $display("FAIL frame_word%0d: got %h want %h", i, start_word_q[s0 + i], exp_word(digits, i));
      else pass_cnt++;
    end
    total_cnt++; if (fd_len_q.size() != f0 + 1) $display("FAIL frame_done_count: got %0d want 1", fd_len_q.size() - f0); else pass_cnt++;
    if (fd_len_q.size() > f0) begin
      total_cnt++; if (fd_len_q[f0] != LC) $display("FAIL frame_done_align: latch cycle %0d want %0d", fd_len_q[f0], LC); else pass_cnt++;
    end
    total_cnt++; if (o_digit_idx !== '0) $display("FAIL frame_idx_wrap: got %0d want 0", o_digit_idx); else pass_cnt++;
    $display("test_frame done");
  endtask

  task automatic test_random();
    int s0, l0, f0, wraps;
    logic [W-1:0] expq[$];
    s0 = start_word_q.size(); l0 = lat_len_q.size(); f0 = fd_len_q.size(); wraps = 0;
    for (int i = 0; i < 7; i++) begin
      digits = $urandom;
      expq.push_back(exp_word(digits, mdl_idx));
      if (mdl_idx == ND - 1) wraps++;
      mdl_idx = (mdl_idx + 1) % ND;
      pulse_tick();
      wait_latches(l0 + i + 1, 300, "random");
      idle($urandom_range(1, 12));
    end
    for (int i = 0; i < 7; i++) begin
      total_cnt++;
      if (start_word_q[s0 + i] !== expq[i]) $display("FAIL random_word%0d: got %h want %h", i, start_word_q[s0 + i], expq[i]);
      else pass_cnt++;
    end
    total_cnt++; if (fd_len_q.size() - f0 != wraps) $display("FAIL random_frames: got %0d want %0d", fd_len_q.size() - f0, wraps); else pass_cnt++;
    $display("test_random done");
  endtask

  task automatic test_back_to_back();
    int s0, l0;
    logic [W-1:0] e0, e1;
    digits = $urandom;
    s0 = start_word_q.size(); l0 = lat_len_q.size();
    e0 = exp_word(digits, mdl_idx); mdl_idx = (mdl_idx + 1) % ND;
    e1 = exp_word(digits, mdl_idx); mdl_idx = (mdl_idx + 1) % ND;
    pulse_tick(); idle(10); pulse_tick(); idle(10); pulse_tick();
    wait_latches(l0 + 2, 400, "b2b");
    idle(150);
    total_cnt++; if (start_word_q.size() != s0 + 2) $display("FAIL b2b_transfers: got %0d want 2", start_word_q.size() - s0); else pass_cnt++;
    if (start_word_q.size() >= s0 + 2) begin
      total_cnt++; if (start_word_q[s0] !== e0) $display("FAIL b2b_word0: got %h want %h", start_word_q[s0], e0); else pass_cnt++;
      total_cnt++; if (start_word_q[s0 + 1] !== e1) $display("FAIL b2b_word1: got %h want %h", start_word_q[s0 + 1], e1); else pass_cnt++;
      total_cnt++;
      if (start_cyc_q[s0 + 1] - lat_rise_q[l0] != LC + 2)
        $display("FAIL b2b_pending_start: gap %0d want %0d", start_cyc_q[s0 + 1] - lat_rise_q[l0], LC + 2);
      else pass_cnt++;
    end
    $display("test_back_to_back done");
  endtask

  task automatic test_tick_at_exit();
    int s0, l0, n;
    logic [W-1:0] e1;
    digits = $urandom;
    s0 = start_word_q.size(); l0 = lat_len_q.size();
    mdl_idx = (mdl_idx + 1) % ND;
    e1 = exp_word(digits, mdl_idx); mdl_idx = (mdl_idx + 1) % ND;
    pulse_tick();
    n = 0;
    do begin @(negedge clk); n++; end while (!o_serial_latch && n < 300);
    total_cnt++; if (!o_serial_latch) $display("FAIL exit_latch_timeout: latch %b want 1", o_serial_latch); else pass_cnt++;
    repeat (LC - 1) @(negedge clk);
    tick = 1'b1;
    @(posedge clk); #1 tick = 1'b0;
    wait_latches(l0 + 2, 400, "exit");
    idle(100);
    total_cnt++; if (start_word_q.size() != s0 + 2) $display("FAIL exit_pending_kept: got %0d want 2", start_word_q.size() - s0); else pass_cnt++;
    if (start_word_q.size() >= s0 + 2) begin
      total_cnt++; if (start_word_q[s0 + 1] !== e1) $display("FAIL exit_word: got %h want %h", start_word_q[s0 + 1], e1); else pass_cnt++;
    end
    $display("test_tick_at_exit done");
  endtask

  task automatic test_snapshot();
    int l0, h0;
    logic [31:0]  d0;
    logic [W-1:0] e0;
    d0 = $urandom; digits = d0;
    e0 = exp_word(d0, mdl_idx); mdl_idx = (mdl_idx + 1) % ND;
    l0 = lat_len_q.size(); h0 = shift_word_q.size();
    pulse_tick();
    @(negedge clk); @(negedge clk);
    digits = ~d0;
    wait_latches(l0 + 1, 300, "snap");
    total_cnt++; if (shift_word_q.size() != h0 + 1 || shift_word_q[h0] !== e0)
      $display("FAIL snap_shifted: got %h want %h", (shift_word_q.size() > h0) ? shift_word_q[h0] : 'x, e0);
    else pass_cnt++;
    total_cnt++; if (o_sr_data !== e0) $display("FAIL snap_hold: got %h want %h", o_sr_data, e0); else pass_cnt++;
    $display("test_snapshot done");
  endtask

  task automatic test_enable_low();
    int s0, l0;
    logic [W-1:0] e1;
    digits = $urandom;
    s0 = start_word_q.size(); l0 = lat_len_q.size();
    mdl_idx = (mdl_idx + 1) % ND;
    pulse_tick(); idle(8);
    en = 1'b0;
    pulse_tick(); idle(5); pulse_tick();
    wait_latches(l0 + 1, 300, "enlow");
    for (int i = 0; i < 3; i++) begin pulse_tick(); idle(40); end
    total_cnt++; if (lat_len_q[l0] != LC) $display("FAIL enlow_latch_done: len %0d want %0d", lat_len_q[l0], LC); else pass_cnt++;
    total_cnt++; if (start_word_q.size() != s0 + 1) $display("FAIL enlow_no_starts: got %0d want 1", start_word_q.size() - s0); else pass_cnt++;
    en = 1'b1; idle(20);
    total_cnt++; if (start_word_q.size() != s0 + 1) $display("FAIL enlow_pending_cleared: got %0d want 1", start_word_q.size() - s0); else pass_cnt++;
    e1 = exp_word(digits, mdl_idx); mdl_idx = (mdl_idx + 1) % ND;
    pulse_tick();
    wait_latches(l0 + 2, 300, "enlow_resume");
    total_cnt++; if (start_word_q.size() != s0 + 2 || start_word_q[s0 + 1] !== e1)
      $display("FAIL enlow_resume_word: count %0d want 2, word want %h", start_word_q.size() - s0, e1);
    else pass_cnt++;
    $display("test_enable_low done");
  endtask

  task automatic test_reset_mid();
    int n;
    digits = $urandom;
    pulse_tick(); idle(12);
    rst_n = 1'b0;
    @(posedge clk); @(negedge clk);
    total_cnt++; if ({o_sr_data, o_sr_start_stb, o_sr_clk_stb, o_serial_latch, o_frame_done} !== '0)
      $display("FAIL midreset_outputs: data %h start %b clk %b latch %b want all 0", o_sr_data, o_sr_start_stb, o_sr_clk_stb, o_serial_latch);
    else pass_cnt++;
    total_cnt++; if (o_digit_idx !== '0) $display("FAIL midreset_idx: got %0d want 0", o_digit_idx); else pass_cnt++;
    @(posedge clk); #1 rst_n = 1'b1; mdl_idx = 0;
    pulse_tick();
    n = 0;
    do begin @(negedge clk); n++; end while (!o_serial_latch && n < 300);
    rst_n = 1'b0;
    @(negedge clk);
    total_cnt++; if (o_serial_latch !== 1'b0) $display("FAIL midreset_latch_drop: got %b want 0", o_serial_latch); else pass_cnt++;
    @(posedge clk); #1 rst_n = 1'b1; mdl_idx = 0;
    idle(3);
    $display("test_reset_mid done");
  endtask

  task automatic test_zero_length();
    int s0, l0;
    sr_dead = 1'b1;
    s0 = start_cyc_q.size(); l0 = lat_len_q.size();
    pulse_tick();
    wait_latches(l0 + 1, 100, "zero");
    total_cnt++; if (lat_rise_q[l0] - start_cyc_q[s0] != 3)
      $display("FAIL zero_latch_delay: got %0d want 3", lat_rise_q[l0] - start_cyc_q[s0]);
    else pass_cnt++;
    total_cnt++; if (lat_len_q[l0] != LC) $display("FAIL zero_latch_len: got %0d want %0d", lat_len_q[l0], LC); else pass_cnt++;
    mdl_idx = (mdl_idx + 1) % ND;
    total_cnt++; if (o_digit_idx !== IW'(mdl_idx)) $display("FAIL zero_idx: got %0d want %0d", o_digit_idx, mdl_idx); else pass_cnt++;
    sr_dead = 1'b0;
    $display("test_zero_length done");
  endtask

  initial begin
    test_reset();
    test_single();
    test_frame();
    test_random();
    test_back_to_back();
    test_tick_at_exit();
    test_snapshot();
    test_enable_low();
    test_reset_mid();
    test_zero_length();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/display_refresh_scheduler.md
# display_refresh_scheduler

Sequencer that time-multiplexes a multi-digit segment display through the shared serial shift/latch chain. On each refresh tick it builds one parallel word (one-hot digit select plus that digit's segment byte), starts the shift transfer, waits for completion, then pulses the output latch. It also generates the serial-clock strobe that paces the shifter. It sits between the clock's display-data logic and the latch shift register instance driving the external 74HC595-style chain.

## Interface
- SEG_WIDTH, 8, segment bits per digit
- NUM_DIGITS, 4, digits scanned; digit index width IDX_W = clog2(NUM_DIGITS), minimum 1
- WIDTH, SEG_WIDTH+NUM_DIGITS, shift word width; must equal the shifter's WIDTH
- CLK_DIV, 4, system clocks per o_sr_clk_stb pulse (≥2)
- LATCH_CYCLES, 2, latch high time in system clocks (≥1)

- i_clk  in  1  system clock
- i_reset_n  in  1  synchronous reset, active low
- i_enable  in  1  scanning enable
- i_refresh_stb  in  1  one-cycle tick; requests the next digit update
- i_digits  in  SEG_WIDTH*NUM_DIGITS  packed segment data; digit k at [k*SEG_WIDTH +: SEG_WIDTH]
- o_sr_data  out  WIDTH  parallel word to shifter: {one-hot select[NUM_DIGITS-1:0], segments[SEG_WIDTH-1:0]}
- o_sr_start_stb  out  1  one-cycle transfer start
- o_sr_clk_stb  out  1  serial pacing strobe to shifter
- i_sr_busy  in  1  shifter busy
- o_serial_latch  out  1  latch (RCLK) to external chain
- o_digit_idx  out  IDX_W  digit currently being sent
- o_frame_done  out  1  one-cycle pulse when the last digit has latched

## Operation
- States: IDLE, LOAD, START, WAIT_HI, WAIT_LO, LATCH.
- IDLE: if i_enable and (i_refresh_stb or pending) → LOAD; clear pending.
- LOAD: register o_sr_data from i_digits at o_digit_idx (snapshot; later i_digits changes ignored). → START.
- START: o_sr_start_stb=1 for exactly this cycle; clear divider counter. → WAIT_HI.
- WAIT_HI: when i_sr_busy=1 → WAIT_LO. If busy not seen within 2 cycles, treat transfer as complete (zero-length) → LATCH.
- WAIT_LO: when i_sr_busy=0 → LATCH.
- LATCH: o_serial_latch=1 for LATCH_CYCLES cycles; on final cycle advance o_digit_idx (NUM_DIGITS-1 wraps to 0, pulsing o_frame_done) → IDLE.
- i_refresh_stb outside IDLE sets a one-deep pending flag; further ticks while pending are dropped.
- i_enable low: current transfer runs to completion through LATCH; pending cleared; stays in IDLE.
- Divider: counter 0..CLK_DIV-1 runs only in WAIT_HI/WAIT_LO; o_sr_clk_stb=1 when counter==CLK_DIV-1; 0 elsewhere.

## Timing
- Reset (sampled low at edge): state IDLE, all outputs 0, o_digit_idx 0, pending 0, divider 0; applies mid-transfer, latch dropped immediately.
- Tick in IDLE at cycle N: LOAD N+1, o_sr_start_stb N+2, o_sr_data stable from N+2 until next LOAD.
- First o_sr_clk_stb CLK_DIV cycles after START cycle, then every CLK_DIV.
- Busy falling at cycle M: o_serial_latch high M+1..M+LATCH_CYCLES; IDLE at M+LATCH_CYCLES+1; pending tick starts LOAD at M+LATCH_CYCLES+1 +1.
- o_frame_done coincides with last latch cycle of digit NUM_DIGITS-1.
- Tick simultaneous with exiting LATCH: captured as pending, not lost.

## Structure
- Shared package: state encoding localparams, default width constants (SEG_WIDTH, NUM_DIGITS).
- One natural sub-module: strobe_divider (clear, enable, CLK_DIV counter, strobe out); reusable elsewhere in the clock.
- Top-level bench instantiates this with the existing latch shift register for integration.

## Test plan
- Reset then single tick, i_digits digit0=8'hA5 -> o_sr_data=12'h1A5, one start pulse, latch high 2 cycles after busy falls, o_digit_idx=1.
- Four ticks spaced wider than a transfer, digits 8'h11/22/33/44 -> words 0x111,0x222,0x433,0x844; o_frame_done once; idx wraps to 0.
- Three ticks during one transfer -> exactly one extra transfer follows; third tick dropped.
- i_digits changed after LOAD -> shifted word unchanged from snapshot.
- i_enable low mid-transfer -> latch completes, no further start pulses despite ticks.
- Reset asserted during WAIT_LO -> next cycle all outputs 0, idx 0; busy never rising -> LATCH after 2 cycles.
